// File: rtl/bist_scan_controller.sv
// bist_scan_controller
//   Sequences one test-per-scan BIST session: pulses reset_internal to initialise the LFSR and
//   MISR, applies N_PATTERNS patterns (N_SCAN shift cycles followed by one capture cycle each),
//   unloads the last response with N_SCAN more shifts, then compares the MISR signature with
//   GOLDEN and reports the result.
//
// Ports
//   clock           in   rising-edge system clock
//   reset           in   asynchronous active-high reset, forces IDLE
//   start           in   session request, honoured in IDLE/DONE only
//   misr_signature  in   current MISR contents, sampled in COMPARE
//   reset_internal  out  one-cycle init strobe to LFSR and MISR
//   control_input   out  LFSR advance enable
//   scan_en         out  1 = shift, 0 = functional capture
//   misr_en         out  MISR compaction enable
//   busy            out  session in progress (INIT..COMPARE)
//   done            out  session finished, pass valid
//   pass            out  signature matched GOLDEN
//   pattern_count   out  patterns captured so far (saturates at N_PATTERNS)
//   sig_captured    out  signature sampled in COMPARE (only with BIST_SIGCAP_EN defined)
//
// Build option
//   BIST_SIGCAP_EN : adds the sig_captured port and its capture register.

module bist_scan_controller #(
  parameter int unsigned N_SCAN     = 4,
  parameter int unsigned N_PATTERNS = 16,
  parameter int unsigned SIG_W      = 5,
  parameter logic [SIG_W-1:0] GOLDEN = '0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [SIG_W-1:0]                  misr_signature,
  output logic                              reset_internal,
  output logic                              control_input,
  output logic                              scan_en,
  output logic                              misr_en,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(N_PATTERNS+1)-1:0]   pattern_count
`ifdef BIST_SIGCAP_EN
  ,
  output logic [SIG_W-1:0]                  sig_captured
`endif
);

  localparam int unsigned SCW = (N_SCAN > 1) ? $clog2(N_SCAN) : 1;
  localparam int unsigned PCW = $clog2(N_PATTERNS + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StInit    = 3'd1,
    StShift   = 3'd2,
    StCapture = 3'd3,
    StUnload  = 3'd4,
    StCompare = 3'd5,
    StDone    = 3'd6
  } state_e;

  state_e           state_d, state_q;
  logic [SCW-1:0]   shift_cnt_d, shift_cnt_q;
  logic [PCW-1:0]   pat_cnt_d, pat_cnt_q;
  logic             pass_d, pass_q;

  logic shift_last;
  logic pat_last;
  logic session_start;

  assign shift_last    = (shift_cnt_q == SCW'(N_SCAN - 1));
  assign pat_last      = (pat_cnt_q == PCW'(N_PATTERNS - 1));
  // Accepting start from IDLE or DONE; the result is cleared on this edge so that done and pass
  // fall together and the INIT cycle already shows a clean session.
  assign session_start = ((state_q == StIdle) || (state_q == StDone)) && start;

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StInit;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
          pass_d      = 1'b0;
        end
      end
      StInit: begin
        state_d     = StShift;
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
        pass_d      = 1'b0;
      end
      StShift: begin
        if (shift_last) begin
          shift_cnt_d = '0;
          state_d     = StCapture;
        end else begin
          shift_cnt_d = shift_cnt_q + SCW'(1);
        end
      end
      StCapture: begin
        if (pat_cnt_q != PCW'(N_PATTERNS)) begin
          pat_cnt_d = pat_cnt_q + PCW'(1);
        end
        shift_cnt_d = '0;
        state_d     = pat_last ? StUnload : StShift;
      end
      StUnload: begin
        if (shift_last) begin
          shift_cnt_d = '0;
          state_d     = StCompare;
        end else begin
          shift_cnt_d = shift_cnt_q + SCW'(1);
        end
      end
      StCompare: begin
        pass_d  = (misr_signature == GOLDEN);
        state_d = StDone;
      end
      default: begin
        state_d     = StIdle;
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
        pass_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  // Moore output decode from the state register only
  always_comb begin
    reset_internal = 1'b0;
    control_input  = 1'b0;
    scan_en        = 1'b0;
    misr_en        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      StInit: begin
        reset_internal = 1'b1;
        busy           = 1'b1;
      end
      StShift: begin
        control_input = 1'b1;
        scan_en       = 1'b1;
        misr_en       = 1'b1;
        busy          = 1'b1;
      end
      StCapture: begin
        busy = 1'b1;
      end
      StUnload: begin
        scan_en = 1'b1;
        misr_en = 1'b1;
        busy    = 1'b1;
      end
      StCompare: begin
        busy = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pass          = pass_q;
  assign pattern_count = pat_cnt_q;

`ifdef BIST_SIGCAP_EN
  logic [SIG_W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (state_q == StCompare) begin
      sig_d = misr_signature;
    end else if (session_start || (state_q == StInit)) begin
      sig_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_captured = sig_q;
`else
  // No signature capture register in this build.
`endif

endmodule
